contrib_accumulator: RTL and testbench

Terminal stage of the range-sum pipeline. Consumes one signed contribution per cycle from the last arithmetic stage: a per-entry repeated-pattern sum, tagged add or subtract for inclusion–exclusion. Keeps a 64-bit running total in a two-half split adder so the 25 MHz target closes with margin. Counts accepted entries, flags misuse, and raises `done` once exactly `ENTRY_COUNT` contributions are fully folded into `total_sum`.

---
 rtl/solver_pkg.sv | 16 +
 rtl/contrib_accumulator_if.sv | 44 ++++
 rtl/half_adder_reg.sv | 35 +++
 rtl/contrib_accumulator.sv | 135 +++++++++++++
 tb/tb_contrib_accumulator.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/solver_pkg.sv
// Definitions shared by the range-sum pipeline: sum widths, the default run
// length and the accumulator's FSM states.
`timescale 1ns / 1ps
package solver_pkg;

    localparam int unsigned SUM_WIDTH           = 64;
    localparam int unsigned HALF_WIDTH          = SUM_WIDTH / 2;
    localparam int unsigned DEFAULT_ENTRY_COUNT = 468;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/contrib_accumulator_if.sv
// Contribution input and accumulator status bundle between the last arithmetic
// stage (master) and contrib_accumulator (slave).
`timescale 1ns / 1ps
interface contrib_accumulator_if
    import solver_pkg::*;
#(
    parameter int unsigned ENTRY_COUNT = DEFAULT_ENTRY_COUNT,
    parameter int unsigned WIDTH       = SUM_WIDTH
);

    localparam int unsigned CW = $clog2(ENTRY_COUNT + 1);

    logic             in_valid;
    logic             in_sub;
    logic [WIDTH-1:0] in_value;
    logic [WIDTH-1:0] total_sum;
    logic             done;
    logic [CW-1:0]    entry_count;
    logic             overflow;
    logic             extra_err;

    modport master (
        output in_valid,
        output in_sub,
        output in_value,
        input  total_sum,
        input  done,
        input  entry_count,
        input  overflow,
        input  extra_err
    );

    modport slave (
        input  in_valid,
        input  in_sub,
        input  in_value,
        output total_sum,
        output done,
        output entry_count,
        output overflow,
        output extra_err
    );

endinterface

// File: rtl/half_adder_reg.sv
// One half of the split running-total adder: acc <= acc + op + cin when enabled,
// exposing the combinational sum and carry-out of that add.
`timescale 1ns / 1ps
module half_adder_reg
    import solver_pkg::*;
#(
    parameter int unsigned H = HALF_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [H-1:0] op,
    input  logic         cin,
    output logic [H-1:0] acc,
    output logic [H-1:0] sum,
    output logic         cout
);

    logic [H-1:0] acc_q;

    always_comb begin
        {cout, sum} = {1'b0, acc_q} + {1'b0, op} + {{H{1'b0}}, cin};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/contrib_accumulator.sv
// Terminal stage of the range-sum pipeline: folds signed contributions into a
// running total held in a two-stage split adder, and reports completion/misuse.
`timescale 1ns / 1ps
module contrib_accumulator
    import solver_pkg::*;
#(
    parameter int unsigned ENTRY_COUNT = DEFAULT_ENTRY_COUNT,
    parameter int unsigned WIDTH       = SUM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    contrib_accumulator_if.slave  bus
);

    localparam int unsigned   H      = WIDTH / 2;
    localparam int unsigned   CW     = $clog2(ENTRY_COUNT + 1);
    localparam logic [CW-1:0] LAST   = CW'(ENTRY_COUNT);
    localparam logic [CW-1:0] PENULT = CW'(ENTRY_COUNT - 1);

    logic [WIDTH-1:0] op;
    logic             at_limit;
    logic             accept;
    logic             last_accept;

    logic [H-1:0]     lo_acc;
    logic             lo_cout;
    logic [H-1:0]     hi_acc;
    logic [H-1:0]     hi_sum;
    logic [H-1:0]     unused_lo_sum;
    logic             unused_hi_cout;

    logic [H-1:0]     hi_op_q;
    logic             hi_v_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             ovf_q;
    logic             ovf_set;
    logic             extra_q;

    acc_state_e       state_q;
    acc_state_e       state_d;

    // The counter saturates at LAST, so "below ENTRY_COUNT" is simply "not at LAST".
    assign at_limit    = (cnt_q == LAST);
    assign accept      = bus.in_valid && !at_limit;
    assign last_accept = accept && (cnt_q == PENULT);

    // Subtraction as ~value + 1, with the +1 entering as the low-half carry-in.
    assign op = bus.in_sub ? ~bus.in_value : bus.in_value;

    half_adder_reg #(
        .H (H)
    ) u_stage_a (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .op   (op[H-1:0]),
        .cin  (bus.in_sub),
        .acc  (lo_acc),
        .sum  (unused_lo_sum),
        .cout (lo_cout)
    );

    half_adder_reg #(
        .H (H)
    ) u_stage_b (
        .clk  (clk),
        .rst  (rst),
        .en   (hi_v_q),
        .op   (hi_op_q),
        .cin  (carry_q),
        .acc  (hi_acc),
        .sum  (hi_sum),
        .cout (unused_hi_cout)
    );

    // Same-sign operands producing a different-sign result.
    always_comb begin
        ovf_set = hi_v_q && (hi_acc[H-1] == hi_op_q[H-1]) && (hi_sum[H-1] != hi_acc[H-1]);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_op_q <= '0;
            hi_v_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            extra_q <= 1'b0;
        end else begin
            hi_v_q  <= accept;
            hi_op_q <= accept ? op[WIDTH-1:H] : '0;
            carry_q <= accept & lo_cout;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_q | ovf_set;
            extra_q <= extra_q | (bus.in_valid & at_limit);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM:   if (last_accept) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        bus.done = (state_q == DONE);
    end

    assign bus.total_sum   = {hi_acc, lo_acc};
    assign bus.entry_count = cnt_q;
    assign bus.overflow    = ovf_q;
    assign bus.extra_err   = extra_q;

endmodule

// File: tb/tb_contrib_accumulator.sv
// Bench for contrib_accumulator: three instances (ENTRY_COUNT 1, 3, 468) checked
// every cycle against a sum-level model, plus literal expectations per scenario.
`timescale 1ns / 1ps
module tb_contrib_accumulator;

    localparam int NDUT = 3;
    localparam logic signed [65:0] SMAX = 66'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        rst_v [NDUT];
    logic        vld   [NDUT];
    logic        sub   [NDUT];
    logic [63:0] val   [NDUT];

    logic [63:0] o_total [NDUT];
    logic        o_done  [NDUT];
    int unsigned o_cnt   [NDUT];
    logic        o_ovf   [NDUT];
    logic        o_extra [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned EC_G = (g == 0) ? 1 : (g == 1) ? 3 : 468;
        contrib_accumulator_if #(.ENTRY_COUNT(EC_G), .WIDTH(64)) bus ();
        assign bus.in_valid = vld[g];
        assign bus.in_sub   = sub[g];
        assign bus.in_value = val[g];
        assign o_total[g]   = bus.total_sum;
        assign o_done[g]    = bus.done;
        assign o_cnt[g]     = 32'(bus.entry_count);
        assign o_ovf[g]     = bus.overflow;
        assign o_extra[g]   = bus.extra_err;
        contrib_accumulator #(.ENTRY_COUNT(EC_G), .WIDTH(64)) dut (
            .clk (clk),
            .rst (rst_v[g]),
            .bus (bus)
        );
    end

    int checks = 0;
    int errors = 0;

    // Model: m_prev = sum of entries accepted up to the previous edge, m_cur up to
    // the latest one; m_fin counts edges since the final entry was accepted.
    logic [63:0] m_prev  [NDUT];
    logic [63:0] m_cur   [NDUT];
    int          m_cnt   [NDUT];
    int          m_fin   [NDUT];
    logic        m_ovf   [NDUT];
    logic        m_pend  [NDUT];
    logic        m_extra [NDUT];

    function automatic int ec_of(int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 468;
        endcase
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset(int k);
        m_prev[k]  = '0;
        m_cur[k]   = '0;
        m_cnt[k]   = 0;
        m_fin[k]   = -1;
        m_ovf[k]   = 1'b0;
        m_pend[k]  = 1'b0;
        m_extra[k] = 1'b0;
    endtask

    task automatic model_edge();
        logic [63:0]       op;
        logic signed [65:0] a, b, r;
        for (int k = 0; k < NDUT; k++) begin
            if (rst_v[k]) begin
                model_reset(k);
            end else begin
                m_prev[k] = m_cur[k];
                m_ovf[k]  = m_ovf[k] | m_pend[k];
                m_pend[k] = 1'b0;
                if (m_fin[k] >= 0 && m_fin[k] < 2) m_fin[k]++;
                if (vld[k]) begin
                    if (m_cnt[k] < ec_of(k)) begin
                        op = sub[k] ? ~val[k] : val[k];
                        a = $signed({{2{m_cur[k][63]}}, m_cur[k]});
                        b = $signed({{2{op[63]}}, op});
                        r = a + b + $signed({65'd0, sub[k]});
                        m_pend[k] = (r > SMAX) || (r < SMIN);
                        m_cur[k] = sub[k] ? m_cur[k] - val[k] : m_cur[k] + val[k];
                        m_cnt[k]++;
                        if (m_cnt[k] == ec_of(k)) m_fin[k] = 0;
                    end else begin
                        m_extra[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic compare_dut(int k);
        check($sformatf("dut%0d total_sum", k), o_total[k], {m_prev[k][63:32], m_cur[k][31:0]});
        check($sformatf("dut%0d entry_count", k), 64'(o_cnt[k]), 64'(m_cnt[k]));
        check($sformatf("dut%0d done", k), 64'(o_done[k]), 64'(m_fin[k] >= 1));
        check($sformatf("dut%0d overflow", k), 64'(o_ovf[k]), 64'(m_ovf[k]));
        check($sformatf("dut%0d extra_err", k), 64'(o_extra[k]), 64'(m_extra[k]));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) compare_dut(k);
    endtask

    task automatic idle_all();
        for (int k = 0; k < NDUT; k++) begin
            vld[k] = 1'b0;
            sub[k] = 1'($urandom);
            val[k] = {$urandom, $urandom};
        end
    endtask

    task automatic drive(int k, logic s, logic [63:0] v);
        idle_all();
        vld[k] = 1'b1;
        sub[k] = s;
        val[k] = v;
    endtask

    // Asserts reset away from the clock edge and expects zeroed outputs at once.
    task automatic do_reset(int k);
        idle_all();
        rst_v[k] = 1'b1;
        #1;
        model_reset(k);
        compare_dut(k);
        check($sformatf("dut%0d total in reset", k), o_total[k], 64'd0);
        check($sformatf("dut%0d count in reset", k), 64'(o_cnt[k]), 64'd0);
        step();
        rst_v[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            rst_v[k] = 1'b1;
            model_reset(k);
        end
        idle_all();
        step();
        for (int k = 0; k < NDUT; k++) rst_v[k] = 1'b0;
        check("reset done", 64'(o_done[2]), 64'd0);

        // Single add with ENTRY_COUNT = 1.
        drive(0, 1'b0, 64'd32976912643);
        step();
        idle_all();
        check("single count", 64'(o_cnt[0]), 64'd1);
        check("single done early", 64'(o_done[0]), 64'd0);
        step();
        check("single total", o_total[0], 64'd32976912643);
        check("single done", 64'(o_done[0]), 64'd1);

        // Input after done is dropped and flagged.
        drive(0, 1'b0, 64'd99);
        step();
        idle_all();
        check("extra err", 64'(o_extra[0]), 64'd1);
        check("extra total", o_total[0], 64'd32976912643);
        check("extra count", 64'(o_cnt[0]), 64'd1);

        // Subtract from zero.
        do_reset(0);
        drive(0, 1'b1, 64'd5);
        step();
        idle_all();
        step();
        check("sub5 total", o_total[0], 64'hFFFF_FFFF_FFFF_FFFB);
        check("sub5 done", 64'(o_done[0]), 64'd1);

        // +1111 +2222 -1111 with ENTRY_COUNT = 3.
        do_reset(1);
        drive(1, 1'b0, 64'd1111);
        step();
        drive(1, 1'b0, 64'd2222);
        step();
        drive(1, 1'b1, 64'd1111);
        step();
        idle_all();
        step();
        check("mix total", o_total[1], 64'd2222);
        check("mix overflow", 64'(o_ovf[1]), 64'd0);
        check("mix done", 64'(o_done[1]), 64'd1);

        // Low-half carry, back-to-back.
        do_reset(2);
        drive(2, 1'b0, 64'hFFFF_FFFF);
        step();
        check("carry first", o_total[2], 64'hFFFF_FFFF);
        drive(2, 1'b0, 64'd1);
        step();
        idle_all();
        check("carry pending", o_total[2], 64'd0);
        step();
        check("carry total", o_total[2], 64'h1_0000_0000);

        // Signed overflow, sticky across a later subtract.
        do_reset(1);
        drive(1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF);
        step();
        drive(1, 1'b0, 64'd1);
        step();
        check("ovf not yet", 64'(o_ovf[1]), 64'd0);
        drive(1, 1'b1, 64'd1);
        step();
        check("ovf set", 64'(o_ovf[1]), 64'd1);
        idle_all();
        step();
        check("ovf sticky", 64'(o_ovf[1]), 64'd1);
        check("ovf total", o_total[1], 64'h7FFF_FFFF_FFFF_FFFF);

        // Reset between stage A and stage B, then a full golden run.
        do_reset(2);
        for (int i = 0; i < 3; i++) begin
            drive(2, 1'b0, 64'd70463488);
            step();
        end
        do_reset(2);
        check("midrst ovf", 64'(o_ovf[2]), 64'd0);
        for (int i = 0; i < 468; i++) begin
            drive(2, 1'b0, (i == 467) ? 64'd70463747 : 64'd70463488);
            step();
        end
        idle_all();
        check("full count", 64'(o_cnt[2]), 64'd468);
        check("full done early", 64'(o_done[2]), 64'd0);
        step();
        check("full total", o_total[2], 64'd32976912643);
        check("full done", 64'(o_done[2]), 64'd1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
